// File: rtl/rv32i_types.sv
// Shared types and width constants for the cache-to-memory arbiter.
// Holds the arbiter FSM state enum, grant enum and line/beat geometry.
package rv32i_types;

    localparam int unsigned ADDR_WIDTH = 32;
    localparam int unsigned LINE_WIDTH = 256;
    localparam int unsigned BEAT_WIDTH = 64;
    localparam int unsigned BURST_LEN  = 4;
    localparam int unsigned BEAT_IDX_W = $clog2(BURST_LEN);

    localparam logic [BEAT_IDX_W-1:0] LAST_BEAT = BEAT_IDX_W'(BURST_LEN - 1);
    localparam logic [ADDR_WIDTH-1:0] LINE_OFFSET_MASK = ADDR_WIDTH'(LINE_WIDTH / 8 - 1);

    typedef enum logic [2:0] {
        IDLE,
        I_READ,
        D_READ,
        D_WRITE,
        DONE
    } arb_state_t;

    typedef enum logic {
        GRANT_I,
        GRANT_D
    } arb_grant_t;

    // Clears the byte-within-line offset so every burst starts on a line boundary.
    function automatic logic [ADDR_WIDTH-1:0] line_align(input logic [ADDR_WIDTH-1:0] addr);
        return addr & ~LINE_OFFSET_MASK;
    endfunction

endpackage

// File: rtl/burst_adapter.sv
// Beat-level datapath for the arbiter: beat counter, shared line buffer
// that gathers read beats, and the mux that slices a writeback line into beats.
module burst_adapter
    import rv32i_types::*;
(
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  start_i,
    input  logic                  rd_en_i,
    input  logic                  wr_en_i,
    input  logic                  done_i,
    input  logic                  mem_resp_i,
    input  logic [BEAT_WIDTH-1:0] mem_rdata_i,
    input  logic [LINE_WIDTH-1:0] wdata_i,
    output logic                  last_beat_o,
    output logic [LINE_WIDTH-1:0] line_o,
    output logic [BEAT_WIDTH-1:0] mem_wdata_o
);

    logic [BEAT_IDX_W-1:0] beat_q, beat_d;
    logic [LINE_WIDTH-1:0] line_q, line_d;
    logic                  beat_ack;

    assign beat_ack = (rd_en_i || wr_en_i) && mem_resp_i;

    always_comb begin
        beat_d = beat_q;
        line_d = line_q;
        if (start_i || done_i) begin
            beat_d = '0;
        end else if (beat_ack) begin
            // Natural 2-bit wrap returns the counter to 0 after the last beat.
            beat_d = beat_q + 1'b1;
        end
        if (rd_en_i && mem_resp_i) begin
            line_d[beat_q*BEAT_WIDTH +: BEAT_WIDTH] = mem_rdata_i;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            beat_q <= '0;
            line_q <= '0;
        end else begin
            beat_q <= beat_d;
            line_q <= line_d;
        end
    end

    always_comb begin
        mem_wdata_o = '0;
        if (wr_en_i) begin
            mem_wdata_o = wdata_i[beat_q*BEAT_WIDTH +: BEAT_WIDTH];
        end
    end

    assign last_beat_o = beat_ack && (beat_q == LAST_BEAT);
    assign line_o      = line_q;

endmodule

// File: rtl/cache_arbiter.sv
// Shares one 64-bit burst memory port between the I-cache and D-cache line ports.
// Define CACHE_ARBITER_RR_EN for round-robin between caches; default is fixed D-over-I.
module cache_arbiter
    import rv32i_types::*;
(
    input  logic                  clk,
    input  logic                  rst,

    input  logic                  icache_pmem_read,
    input  logic [ADDR_WIDTH-1:0] icache_pmem_address,
    output logic [LINE_WIDTH-1:0] icache_pmem_rdata,
    output logic                  icache_pmem_resp,

    input  logic                  dcache_pmem_read,
    input  logic                  dcache_pmem_write,
    input  logic [ADDR_WIDTH-1:0] dcache_pmem_address,
    input  logic [LINE_WIDTH-1:0] dcache_pmem_wdata,
    output logic [LINE_WIDTH-1:0] dcache_pmem_rdata,
    output logic                  dcache_pmem_resp,

    output logic                  mem_read,
    output logic                  mem_write,
    output logic [ADDR_WIDTH-1:0] mem_address,
    output logic [BEAT_WIDTH-1:0] mem_wdata,
    input  logic [BEAT_WIDTH-1:0] mem_rdata,
    input  logic                  mem_resp
);

    arb_state_t            state_q, state_d;
    arb_grant_t            grant_q, grant_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;

    logic                  d_req;
    logic                  i_req;
    logic                  pick_d;
    logic                  last_beat;
    logic [LINE_WIDTH-1:0] line_buf;

    assign d_req = dcache_pmem_read || dcache_pmem_write;
    assign i_req = icache_pmem_read;

`ifdef CACHE_ARBITER_RR_EN
    // grant_q doubles as last_grant: on a collision the cache not served last wins.
    assign pick_d = d_req && (!i_req || (grant_q == GRANT_I));
`else
    assign pick_d = d_req;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            grant_q <= GRANT_D;
            addr_q  <= '0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            addr_q  <= addr_d;
        end
    end

    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        addr_d  = addr_q;
        unique case (state_q)
            IDLE: begin
                if (pick_d) begin
                    grant_d = GRANT_D;
                    addr_d  = line_align(dcache_pmem_address);
                    // Write wins if both D-side strobes are up.
                    state_d = dcache_pmem_write ? D_WRITE : D_READ;
                end else if (i_req) begin
                    grant_d = GRANT_I;
                    addr_d  = line_align(icache_pmem_address);
                    state_d = I_READ;
                end
            end
            I_READ, D_READ, D_WRITE: begin
                if (last_beat) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_comb begin
        mem_read         = 1'b0;
        mem_write        = 1'b0;
        icache_pmem_resp = 1'b0;
        dcache_pmem_resp = 1'b0;
        unique case (state_q)
            I_READ, D_READ: mem_read  = 1'b1;
            D_WRITE:        mem_write = 1'b1;
            DONE: begin
                icache_pmem_resp = (grant_q == GRANT_I);
                dcache_pmem_resp = (grant_q == GRANT_D);
            end
            default: ;
        endcase
    end

    assign mem_address       = addr_q;
    assign icache_pmem_rdata = line_buf;
    assign dcache_pmem_rdata = line_buf;

    burst_adapter u_burst (
        .clk_i       (clk),
        .rst_i       (rst),
        .start_i     ((state_q == IDLE) && (state_d != IDLE)),
        .rd_en_i     (mem_read),
        .wr_en_i     (mem_write),
        .done_i      (state_q == DONE),
        .mem_resp_i  (mem_resp),
        .mem_rdata_i (mem_rdata),
        .wdata_i     (dcache_pmem_wdata),
        .last_beat_o (last_beat),
        .line_o      (line_buf),
        .mem_wdata_o (mem_wdata)
    );

endmodule

// File: tb/tb_cache_arbiter.sv
// Directed self-checking bench for cache_arbiter with a negedge-driven burst memory model.
// Expected grant order follows CACHE_ARBITER_RR_EN when it is defined.
module tb_cache_arbiter;

    logic         clk = 1'b0;
    logic         rst;
    logic         icache_pmem_read;
    logic [31:0]  icache_pmem_address;
    logic [255:0] icache_pmem_rdata;
    logic         icache_pmem_resp;
    logic         dcache_pmem_read;
    logic         dcache_pmem_write;
    logic [31:0]  dcache_pmem_address;
    logic [255:0] dcache_pmem_wdata;
    logic [255:0] dcache_pmem_rdata;
    logic         dcache_pmem_resp;
    logic         mem_read;
    logic         mem_write;
    logic [31:0]  mem_address;
    logic [63:0]  mem_wdata;
    logic [63:0]  mem_rdata;
    logic         mem_resp;

    cache_arbiter u_dut (
        .clk                 (clk),
        .rst                 (rst),
        .icache_pmem_read    (icache_pmem_read),
        .icache_pmem_address (icache_pmem_address),
        .icache_pmem_rdata   (icache_pmem_rdata),
        .icache_pmem_resp    (icache_pmem_resp),
        .dcache_pmem_read    (dcache_pmem_read),
        .dcache_pmem_write   (dcache_pmem_write),
        .dcache_pmem_address (dcache_pmem_address),
        .dcache_pmem_wdata   (dcache_pmem_wdata),
        .dcache_pmem_rdata   (dcache_pmem_rdata),
        .dcache_pmem_resp    (dcache_pmem_resp),
        .mem_read            (mem_read),
        .mem_write           (mem_write),
        .mem_address         (mem_address),
        .mem_wdata           (mem_wdata),
        .mem_rdata           (mem_rdata),
        .mem_resp            (mem_resp)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk) begin
        if (!rst) begin
            assert (!(dcache_pmem_read && dcache_pmem_write))
                else $error("protocol: dcache read and write raised together");
        end
    end

    int tests_run = 0;
    int tests_failed = 0;

    // Memory model and response monitor state
    int           waits;
    int           wait_cnt;
    logic [1:0]   mbeat;
    logic [63:0]  beats [4];
    logic [63:0]  wr_log [4];
    int           i_resp_cnt, d_resp_cnt, i_resp_cyc, d_resp_cyc, overlap_cnt;
    logic [255:0] i_rdata_cap, d_rdata_cap;
    int           c0, i_cnt0, d_cnt0;
    bit           seen;

    task automatic check_eq(input string tag, input logic [255:0] got, input logic [255:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // One clock: monitor outputs, drop requests after resp, then drive the memory beat.
    task automatic step();
        @(negedge clk);
        if (mem_read && mem_write) overlap_cnt++;
        if (icache_pmem_resp) begin
            i_resp_cnt++;
            i_resp_cyc  = cyc;
            i_rdata_cap = icache_pmem_rdata;
            icache_pmem_read = 1'b0;
        end
        if (dcache_pmem_resp) begin
            d_resp_cnt++;
            d_resp_cyc  = cyc;
            d_rdata_cap = dcache_pmem_rdata;
            dcache_pmem_read  = 1'b0;
            dcache_pmem_write = 1'b0;
        end
        if (rst || !(mem_read || mem_write)) begin
            mem_resp = 1'b0;
            wait_cnt = 0;
            mbeat    = 2'd0;
        end else if (wait_cnt == waits) begin
            mem_resp  = 1'b1;
            mem_rdata = beats[mbeat];
            if (mem_write) wr_log[mbeat] = mem_wdata;
            mbeat    = mbeat + 2'd1;
            wait_cnt = 0;
        end else begin
            mem_resp = 1'b0;
            wait_cnt++;
        end
    endtask

    task automatic wait_resp(input string tag, input bit is_d, input int limit);
        int start;
        start = is_d ? d_resp_cnt : i_resp_cnt;
        seen  = 1'b0;
        for (int k = 0; k < limit && !seen; k++) begin
            step();
            if ((is_d ? d_resp_cnt : i_resp_cnt) != start) seen = 1'b1;
        end
        check_eq({tag, "_resp_seen"}, 256'(seen), 256'(1'b1));
    endtask

    task automatic set_beats(input logic [63:0] b0, input logic [63:0] b1,
                             input logic [63:0] b2, input logic [63:0] b3);
        beats[0] = b0;
        beats[1] = b1;
        beats[2] = b2;
        beats[3] = b3;
    endtask

    initial begin
        rst = 1'b1;
        icache_pmem_read = 1'b0;
        icache_pmem_address = 32'h0;
        dcache_pmem_read = 1'b0;
        dcache_pmem_write = 1'b0;
        dcache_pmem_address = 32'hFFFF_FFFF;
        dcache_pmem_wdata = {4{64'hDEAD_BEEF_CAFE_F00D}};
        mem_rdata = 64'h0;
        mem_resp = 1'b0;
        waits = 0; wait_cnt = 0; mbeat = 2'd0;
        i_resp_cnt = 0; d_resp_cnt = 0; i_resp_cyc = 0; d_resp_cyc = 0; overlap_cnt = 0;
        i_rdata_cap = '0; d_rdata_cap = '0;
        for (int k = 0; k < 4; k++) begin
            beats[k]  = 64'h0;
            wr_log[k] = 64'h0;
        end

        // Reset state
        repeat (3) step();
        check_eq("rst_mem_read", 256'(mem_read), 256'(1'b0));
        check_eq("rst_mem_write", 256'(mem_write), 256'(1'b0));
        check_eq("rst_mem_address", 256'(mem_address), 256'(32'h0));
        check_eq("rst_mem_wdata", 256'(mem_wdata), 256'(64'h0));
        check_eq("rst_i_resp", 256'(icache_pmem_resp), 256'(1'b0));
        check_eq("rst_d_resp", 256'(dcache_pmem_resp), 256'(1'b0));
        check_eq("rst_i_rdata", icache_pmem_rdata, 256'h0);
        check_eq("rst_d_rdata", dcache_pmem_rdata, 256'h0);
        check_eq("rst_beat", 256'(u_dut.u_burst.beat_q), 256'(2'd0));
        rst = 1'b0;
        step();

        // Single I read, zero wait
        set_beats(64'h1111_1111_1111_1111, 64'h2222_2222_2222_2222,
                  64'h3333_3333_3333_3333, 64'h4444_4444_4444_4444);
        waits = 0;
        icache_pmem_address = 32'h0000_0064;
        icache_pmem_read = 1'b1;
        c0 = cyc;
        step();
        check_eq("iread_mem_read", 256'(mem_read), 256'(1'b1));
        check_eq("iread_mem_address", 256'(mem_address), 256'(32'h0000_0060));
        wait_resp("iread", 1'b0, 20);
        check_eq("iread_latency", 256'(i_resp_cyc - c0), 256'(5));
        check_eq("iread_rdata", i_rdata_cap,
                 256'h4444444444444444_3333333333333333_2222222222222222_1111111111111111);
        step();

        // D writeback, two wait cycles per beat
        waits = 2;
        dcache_pmem_address = 32'h0000_1234;
        dcache_pmem_wdata =
            256'h0123456789ABCDEF_FEDCBA9876543210_0011223344556677_8899AABBCCDDEEFF;
        dcache_pmem_write = 1'b1;
        c0 = cyc;
        step();
        check_eq("dwr_mem_write", 256'(mem_write), 256'(1'b1));
        check_eq("dwr_mem_address", 256'(mem_address), 256'(32'h0000_1220));
        wait_resp("dwr", 1'b1, 40);
        check_eq("dwr_latency", 256'(d_resp_cyc - c0), 256'(13));
        check_eq("dwr_beat0", 256'(wr_log[0]), 256'(64'h8899AABBCCDDEEFF));
        check_eq("dwr_beat1", 256'(wr_log[1]), 256'(64'h0011223344556677));
        check_eq("dwr_beat2", 256'(wr_log[2]), 256'(64'hFEDCBA9876543210));
        check_eq("dwr_beat3", 256'(wr_log[3]), 256'(64'h0123456789ABCDEF));
        step();

        // Simultaneous I and D read
        waits = 0;
        set_beats(64'hA0A0_A0A0_A0A0_A0A0, 64'hB1B1_B1B1_B1B1_B1B1,
                  64'hC2C2_C2C2_C2C2_C2C2, 64'hD3D3_D3D3_D3D3_D3D3);
        icache_pmem_address = 32'h0000_0200;
        dcache_pmem_address = 32'h0000_0300;
        icache_pmem_read = 1'b1;
        dcache_pmem_read = 1'b1;
        i_cnt0 = i_resp_cnt;
        d_cnt0 = d_resp_cnt;
        c0 = cyc;
        seen = 1'b0;
        for (int k = 0; k < 40 && !seen; k++) begin
            step();
            if (i_resp_cnt != i_cnt0 && d_resp_cnt != d_cnt0) seen = 1'b1;
        end
        check_eq("coll_both_seen", 256'(seen), 256'(1'b1));
`ifdef CACHE_ARBITER_RR_EN
        check_eq("coll_i_latency", 256'(i_resp_cyc - c0), 256'(5));
        check_eq("coll_d_latency", 256'(d_resp_cyc - c0), 256'(11));
`else
        check_eq("coll_d_latency", 256'(d_resp_cyc - c0), 256'(5));
        check_eq("coll_i_latency", 256'(i_resp_cyc - c0), 256'(11));
`endif
        check_eq("coll_i_rdata", i_rdata_cap,
                 256'hD3D3D3D3D3D3D3D3_C2C2C2C2C2C2C2C2_B1B1B1B1B1B1B1B1_A0A0A0A0A0A0A0A0);
        check_eq("coll_d_rdata", d_rdata_cap,
                 256'hD3D3D3D3D3D3D3D3_C2C2C2C2C2C2C2C2_B1B1B1B1B1B1B1B1_A0A0A0A0A0A0A0A0);
        step();

        // Write followed by read to the same line
        dcache_pmem_address = 32'h8000_0000;
        dcache_pmem_wdata = {64'h4, 64'h3, 64'h2, 64'h1};
        dcache_pmem_write = 1'b1;
        c0 = cyc;
        step();
        check_eq("wr2rd_wr_address", 256'(mem_address), 256'(32'h8000_0000));
        wait_resp("wr2rd_wr", 1'b1, 20);
        check_eq("wr2rd_wr_latency", 256'(d_resp_cyc - c0), 256'(5));
        step();
        check_eq("wr2rd_idle_write", 256'(mem_write), 256'(1'b0));
        check_eq("wr2rd_idle_read", 256'(mem_read), 256'(1'b0));
        set_beats(64'h5555_5555_5555_5555, 64'h6666_6666_6666_6666,
                  64'h7777_7777_7777_7777, 64'h8888_8888_8888_8888);
        dcache_pmem_read = 1'b1;
        c0 = cyc;
        step();
        check_eq("wr2rd_rd_mem_read", 256'(mem_read), 256'(1'b1));
        wait_resp("wr2rd_rd", 1'b1, 20);
        check_eq("wr2rd_rd_latency", 256'(d_resp_cyc - c0), 256'(5));
        check_eq("wr2rd_rd_rdata", d_rdata_cap,
                 256'h8888888888888888_7777777777777777_6666666666666666_5555555555555555);
        check_eq("no_read_write_overlap", 256'(overlap_cnt), 256'(0));
        step();

        // Reset in the middle of a D read
        dcache_pmem_address = 32'h0000_0040;
        dcache_pmem_read = 1'b1;
        d_cnt0 = d_resp_cnt;
        repeat (3) step();
        check_eq("midrst_beat_before", 256'(u_dut.u_burst.beat_q), 256'(2'd2));
        rst = 1'b1;
        dcache_pmem_read = 1'b0;
        step();
        check_eq("midrst_mem_read", 256'(mem_read), 256'(1'b0));
        check_eq("midrst_mem_address", 256'(mem_address), 256'(32'h0));
        check_eq("midrst_d_rdata", dcache_pmem_rdata, 256'h0);
        check_eq("midrst_beat", 256'(u_dut.u_burst.beat_q), 256'(2'd0));
        rst = 1'b0;
        repeat (2) step();
        check_eq("midrst_no_resp", 256'(d_resp_cnt), 256'(d_cnt0));

        set_beats(64'h9999_9999_9999_9999, 64'hAAAA_AAAA_AAAA_AAAA,
                  64'hBBBB_BBBB_BBBB_BBBB, 64'hCCCC_CCCC_CCCC_CCCC);
        icache_pmem_address = 32'h0000_011F;
        icache_pmem_read = 1'b1;
        c0 = cyc;
        step();
        check_eq("postrst_mem_address", 256'(mem_address), 256'(32'h0000_0100));
        wait_resp("postrst", 1'b0, 20);
        check_eq("postrst_latency", 256'(i_resp_cyc - c0), 256'(5));
        check_eq("postrst_rdata", i_rdata_cap,
                 256'hCCCCCCCCCCCCCCCC_BBBBBBBBBBBBBBBB_AAAAAAAAAAAAAAAA_9999999999999999);
        step();

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running at %0t, limit 200000", $time);
        $fatal(1, "watchdog expired");
    end

endmodule
